ping_pong_checker: RTL



---
 rtl/ping_pong_pkg.sv | 43 ++++
 rtl/ping_pong_predictor.sv | 24 ++
 rtl/ping_pong_checker.sv | 105 ++++++++++
 3 files changed

// File: rtl/ping_pong_pkg.sv
// Shared types and the ping-pong step rule used by the checker and by counter models.
package ping_pong_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACK    = 2'd1,
    FAULT    = 2'd2
  } pp_state_e;

  typedef struct packed {
    logic [31:0] cnt;
    logic        dir;
  } pp_step_t;

  // Next {cnt, dir} of a ping-pong counter; callers truncate cnt to their width.
  function automatic pp_step_t pp_next(input logic [31:0] cnt, input logic dir,
                                       input logic en, input logic [31:0] min_v,
                                       input logic [31:0] max_v);
    pp_step_t r;
    r.cnt = cnt;
    r.dir = dir;
    if (en) begin
      if (dir == DIR_UP) begin
        if (cnt < max_v) r.cnt = cnt + 32'd1;
        else begin
          r.cnt = max_v - 32'd1;
          r.dir = DIR_DOWN;
        end
      end else begin
        if (cnt > min_v) r.cnt = cnt - 32'd1;
        else begin
          r.cnt = min_v + 32'd1;
          r.dir = DIR_UP;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ping_pong_predictor.sv
// Combinational prediction of the next (count, direction) sample from the stored baseline.
module ping_pong_predictor
  import ping_pong_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 15,
  parameter int MIN   = 0
) (
  input  logic [WIDTH-1:0] base_cnt,
  input  logic             base_dir,
  input  logic             base_en,
  output logic [WIDTH-1:0] pred_cnt,
  output logic             pred_dir
);

  pp_step_t step;

  always_comb begin
    step     = pp_next(32'(base_cnt), base_dir, base_en, 32'(MIN), 32'(MAX));
    pred_cnt = WIDTH'(step.cnt);
    pred_dir = step.dir;
  end

endmodule

// File: rtl/ping_pong_checker.sv
// Monitor for the ping-pong counter stream: flags wrong samples and counts bounces.
// Build option PING_PONG_CHECKER_RESYNC_EN: FAULT resynchronises after one cycle instead of latching.
//
//   state    | meaning
//   UNLOCKED | no valid baseline; capture samples until one is in range
//   TRACK    | compare each sample with the prediction, then adopt it as baseline
//   FAULT    | a mismatch was seen; absorbing, or one-cycle resync when enabled
module ping_pong_checker
  import ping_pong_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 15,
  parameter int MIN      = 0,
  parameter int BOUNCE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                direction,
  input  logic [WIDTH-1:0]    count,
  output logic                locked,
  output logic                mismatch,
  output logic                err_flag,
  output logic [BOUNCE_W-1:0] bounce_cnt
);

  localparam logic [1:0] ST_UNLOCKED = 2'(UNLOCKED);
  localparam logic [1:0] ST_TRACK    = 2'(TRACK);
  localparam logic [1:0] ST_FAULT    = 2'(FAULT);

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] base_cnt, pred_cnt;
  logic             base_dir, base_en, pred_dir;
  logic             capture, flag, bump, in_range, sample_ok;
  int               count_i;

  ping_pong_predictor #(.WIDTH(WIDTH), .MAX(MAX), .MIN(MIN)) u_pred (
    .base_cnt(base_cnt),
    .base_dir(base_dir),
    .base_en (base_en),
    .pred_cnt(pred_cnt),
    .pred_dir(pred_dir)
  );

  assign count_i   = 32'(count);
  assign in_range  = (count_i >= MIN) && (count_i <= MAX);
  assign sample_ok = in_range && (count == pred_cnt) && (direction == pred_dir);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    flag      = 1'b0;
    bump      = 1'b0;
    case (state)
      ST_UNLOCKED: begin
        capture   = 1'b1;
        state_nxt = in_range ? ST_TRACK : ST_UNLOCKED;
      end
      ST_TRACK: begin
        capture = 1'b1;
        if (!sample_ok) begin
          flag      = 1'b1;
          state_nxt = ST_FAULT;
        end else begin
          bump = (direction != base_dir);
        end
      end
      ST_FAULT: begin
`ifdef PING_PONG_CHECKER_RESYNC_EN
        // Re-baseline on the sample following the bad one so tracking resumes immediately.
        capture   = 1'b1;
        state_nxt = in_range ? ST_TRACK : ST_UNLOCKED;
`else
        state_nxt = ST_FAULT;
`endif
      end
      default: state_nxt = ST_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_UNLOCKED;
      base_cnt   <= '0;
      base_dir   <= 1'b0;
      base_en    <= 1'b0;
      locked     <= 1'b0;
      mismatch   <= 1'b0;
      err_flag   <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      state    <= state_nxt;
      locked   <= (state_nxt == ST_TRACK);
      mismatch <= flag;
      if (flag) err_flag <= 1'b1;
      if (bump && (bounce_cnt != '1)) bounce_cnt <= bounce_cnt + BOUNCE_W'(1);
      if (capture) begin
        base_cnt <= count;
        base_dir <= direction;
        base_en  <= enable;
      end
    end
  end

endmodule
